// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file and trap/MRET sequencer for the RV32 pipeline
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   csr_addr        CSR address from inst[31:20]
//   csr_wdata       write operand (rs1 value)
//   csr_reg_rd      CSRRS-type read strobe
//   csr_reg_wr      CSRRW write strobe
//   is_mret         MRET strobe
//   instr_valid     current instruction is real (not a bubble/flush)
//   pc_in           PC of the current instruction
//   ext_irq         asynchronous external interrupt level
//   timer_irq       asynchronous timer interrupt level
//   csr_rdata       combinational CSR read data
//   epc_taken       registered PC-redirect strobe
//   epc_out         registered redirect target
//   trap_busy       high in TRAP or RET state; pipeline flushes
module csr_unit #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
    parameter int          NUM_IRQ_SYNC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_reg_rd,
    input  logic        csr_reg_wr,
    input  logic        is_mret,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc_out,
    output logic        trap_busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    // A depth below one would leave the irqs unsynchronized.
    localparam int SYNC_DEPTH = (NUM_IRQ_SYNC < 1) ? 1 : NUM_IRQ_SYNC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_RET
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_DEPTH-1:0] ext_sync;
    logic [SYNC_DEPTH-1:0] timer_sync;
    logic                  meip;
    logic                  mtip;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mie_meie;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic [29:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] mtvec_val;
    logic        pend;
    logic [3:0]  cause;
    logic        is_idle;
    logic        mret_take;
    logic        trap_take;
    logic        wr_en;
    logic [31:0] trap_target;

    // pc_in is word aligned; its low bits never reach a register.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc_in[1:0];

    // ---------------------------------------------------------------
    // irq synchronizers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_sync   <= '0;
            timer_sync <= '0;
        end else begin
            ext_sync[0]   <= ext_irq;
            timer_sync[0] <= timer_irq;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                ext_sync[i]   <= ext_sync[i-1];
                timer_sync[i] <= timer_sync[i-1];
            end
        end
    end

    assign meip = ext_sync[SYNC_DEPTH-1];
    assign mtip = timer_sync[SYNC_DEPTH-1];

    // ---------------------------------------------------------------
    // CSR views and trap decision
    // ---------------------------------------------------------------
    assign mstatus_val = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
    assign mie_val     = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
    assign mip_val     = {20'd0, meip, 3'd0, mtip, 7'd0};
    assign mtvec_val   = {mtvec_base, 1'b0, mtvec_mode};

    assign pend  = mstatus_mie & (|(mip_val & mie_val));
    assign cause = (meip & mie_meie) ? 4'd11 : 4'd7;

    assign is_idle   = (state == S_IDLE);
    // MRET wins over a pending interrupt in the same cycle.
    assign mret_take = is_idle & is_mret & instr_valid;
    assign trap_take = is_idle & ~mret_take & pend & instr_valid;
    // A trap flushes the instruction, so its CSR write must not land.
    assign wr_en     = is_idle & csr_reg_wr & instr_valid & ~trap_take & ~mret_take;

    assign trap_target = mtvec_mode ? ({mtvec_base, 2'b00} + {26'd0, cause, 2'b00})
                                    : {mtvec_base, 2'b00};

    // Combinational read; in a write cycle this is the pre-write value.
    always_comb begin
        csr_rdata = 32'd0;
        if ((csr_reg_rd | csr_reg_wr) & instr_valid) begin
            case (csr_addr)
                ADDR_MSTATUS: csr_rdata = mstatus_val;
                ADDR_MIE:     csr_rdata = mie_val;
                ADDR_MTVEC:   csr_rdata = mtvec_val;
                ADDR_MEPC:    csr_rdata = {mepc, 2'b00};
                ADDR_MCAUSE:  csr_rdata = mcause;
                ADDR_MIP:     csr_rdata = mip_val;
                ADDR_MCYCLE:  csr_rdata = mcycle[31:0];
                ADDR_MCYCLEH: csr_rdata = mcycle[63:32];
                default:      csr_rdata = 32'd0;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        trap_busy  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mret_take) begin
                    state_next = S_RET;
                end else if (trap_take) begin
                    state_next = S_TRAP;
                end
            end
            S_TRAP: begin
                trap_busy  = 1'b1;
                state_next = S_IDLE;
            end
            S_RET: begin
                trap_busy  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Redirect is registered on the same edge that enters TRAP/RET, so it
    // is visible for exactly the one cycle spent in that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_taken <= 1'b0;
            epc_out   <= 32'd0;
        end else begin
            epc_taken <= trap_take | mret_take;
            if (trap_take) begin
                epc_out <= trap_target;
            end else if (mret_take) begin
                epc_out <= {mepc, 2'b00};
            end
        end
    end

    // ---------------------------------------------------------------
    // CSR state
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (mret_take) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (trap_take) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (wr_en && csr_addr == ADDR_MSTATUS) begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_mtie   <= 1'b0;
            mie_meie   <= 1'b0;
            mtvec_base <= RESET_MTVEC[31:2];
            mtvec_mode <= RESET_MTVEC[0];
        end else if (wr_en) begin
            if (csr_addr == ADDR_MIE) begin
                mie_mtie <= csr_wdata[7];
                mie_meie <= csr_wdata[11];
            end
            if (csr_addr == ADDR_MTVEC) begin
                mtvec_base <= csr_wdata[31:2];
                mtvec_mode <= csr_wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mepc   <= 30'd0;
            mcause <= 32'd0;
        end else if (trap_take) begin
            mepc   <= pc_in[31:2];
            mcause <= {1'b1, 27'd0, cause};
        end else if (wr_en) begin
            if (csr_addr == ADDR_MEPC) begin
                mepc <= csr_wdata[31:2];
            end
            if (csr_addr == ADDR_MCAUSE) begin
                mcause <= csr_wdata;
            end
        end
    end

    // A software write to either half replaces it and skips that cycle's tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle <= 64'd0;
        end else if (wr_en && csr_addr == ADDR_MCYCLE) begin
            mcycle[31:0] <= csr_wdata;
        end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
            mcycle[63:32] <= csr_wdata;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit
module tb_csr_unit;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_reg_rd;
    logic        csr_reg_wr;
    logic        is_mret;
    logic        instr_valid;
    logic [31:0] pc_in;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc_out;
    logic        trap_busy;

    int total;
    int passed;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    logic [63:0] got;
    logic [31:0] rd_v;

    csr_unit #(
        .RESET_MTVEC (32'h0000_0080),
        .NUM_IRQ_SYNC(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_reg_rd (csr_reg_rd),
        .csr_reg_wr (csr_reg_wr),
        .is_mret    (is_mret),
        .instr_valid(instr_valid),
        .pc_in      (pc_in),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .csr_rdata  (csr_rdata),
        .epc_taken  (epc_taken),
        .epc_out    (epc_out),
        .trap_busy  (trap_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; csr_addr = '0; csr_wdata = '0; csr_reg_rd = 0; csr_reg_wr = 0;
        is_mret = 0; instr_valid = 0; pc_in = '0; ext_irq = 0; timer_irq = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_addr = a; csr_wdata = d; csr_reg_wr = 1'b1; instr_valid = 1'b1;
        @(negedge clk);
        csr_reg_wr = 1'b0; instr_valid = 1'b0;
    endtask

    // Strobes are dropped before the rising edge so a read never triggers a trap.
    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a; csr_reg_rd = 1'b1; csr_reg_wr = 1'b0; instr_valid = 1'b1;
        #2 d = csr_rdata;
        #1 csr_reg_rd = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] a[6] = '{12'h305, 12'h300, 12'h304, 12'h341, 12'h342, 12'h344};
        logic [31:0] e[6] = '{32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        exp_q.push_back(64'd0);
        got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL reset_status: got %h expected %h", got, exp_v); else passed++;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({32'd0, e[i]});
            csr_read(a[i], rd_v);
            got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
            if (got !== exp_v) $display("FAIL reset_read_%h: got %h expected %h", a[i], got, exp_v); else passed++;
        end
    endtask

    task automatic test_csr_rw();
        logic [11:0] a[5] = '{12'h305, 12'h7C0, 12'h305, 12'h341, 12'h304};
        logic [31:0] e[5] = '{32'h101, 32'h0, 32'h101, 32'h44, 32'h880};
        do_reset();
        // Read strobe without instr_valid returns zero.
        exp_q.push_back(64'd0);
        csr_addr = 12'h305; csr_reg_rd = 1'b1; instr_valid = 1'b0;
        #2 got = {32'd0, csr_rdata}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL rd_no_valid: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk); csr_reg_rd = 1'b0;
        // The write cycle itself shows the pre-write value.
        exp_q.push_back(64'd0);
        csr_addr = 12'h304; csr_wdata = 32'hFFFF_FFFF; csr_reg_wr = 1'b1; instr_valid = 1'b1;
        #2 got = {32'd0, csr_rdata}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL pre_write_value: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk); csr_reg_wr = 1'b0; instr_valid = 1'b0;
        csr_write(12'h305, 32'h0000_0103);
        csr_write(12'h7C0, 32'hDEAD_BEEF);
        csr_write(12'h341, 32'h0000_0047);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({32'd0, e[i]});
            csr_read(a[i], rd_v);
            got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
            if (got !== exp_v) $display("FAIL rw_read_%h: got %h expected %h", a[i], got, exp_v); else passed++;
        end
    endtask

    task automatic test_mcycle();
        logic [11:0] a[4] = '{12'hB00, 12'hB80, 12'hB00, 12'hB80};
        logic [31:0] e[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0};
        do_reset();
        // Writing the high half must not tick the low half.
        csr_write(12'hB00, 32'h5);
        csr_write(12'hB80, 32'h7);
        exp_q.push_back(64'h5);
        csr_read(12'hB00, rd_v);
        got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mcycle_drop_inc: got %h expected %h", got, exp_v); else passed++;
        exp_q.push_back(64'h7);
        csr_read(12'hB80, rd_v);
        got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mcycleh_write: got %h expected %h", got, exp_v); else passed++;
        csr_write(12'hB80, 32'hFFFF_FFFF);
        csr_write(12'hB00, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'd0, e[i]});
            csr_read(a[i], rd_v);
            got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
            if (got !== exp_v) $display("FAIL mcycle_wrap_%0d: got %h expected %h", i, got, exp_v); else passed++;
        end
    endtask

    task automatic test_trap_direct();
        logic [11:0] a[4] = '{12'h341, 12'h342, 12'h300, 12'h304};
        logic [31:0] e[4] = '{32'h40, 32'h8000_000B, 32'h80, 32'h800};
        logic [31:0] m[3] = '{32'h0, 32'h0, 32'h800};
        do_reset();
        csr_write(12'h304, 32'h800);
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        ext_irq = 1'b1;
        // Two synchronizer stages: mip shows the irq after the second edge.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'd0, m[i]});
            csr_read(12'h344, rd_v);
            got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
            if (got !== exp_v) $display("FAIL irq_latency_%0d: got %h expected %h", i, got, exp_v); else passed++;
        end
        // Trap fires with a CSRRW to mie in flight; that write must be dropped.
        pc_in = 32'h40; instr_valid = 1'b1; csr_reg_wr = 1'b1; csr_addr = 12'h304; csr_wdata = 32'h0;
        exp_q.push_back({30'd0, 1'b1, 1'b1, 32'h100});
        @(negedge clk);
        instr_valid = 1'b0; csr_reg_wr = 1'b0;
        #2 got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL trap_direct_redirect: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk);
        exp_q.push_back({30'd0, 1'b0, 1'b0, 32'h100});
        got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL trap_direct_after: got %h expected %h", got, exp_v); else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'd0, e[i]});
            csr_read(a[i], rd_v);
            got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
            if (got !== exp_v) $display("FAIL trap_direct_%h: got %h expected %h", a[i], got, exp_v); else passed++;
        end
    endtask

    // Continues from test_trap_direct with ext_irq still asserted.
    task automatic test_mret();
        is_mret = 1'b1; instr_valid = 1'b1; pc_in = 32'h44;
        @(negedge clk);
        is_mret = 1'b0; pc_in = 32'h80; csr_reg_rd = 1'b1; csr_addr = 12'h300;
        exp_q.push_back({32'd0, 32'h88});
        exp_q.push_back({30'd0, 1'b1, 1'b1, 32'h40});
        #2 got = {32'd0, csr_rdata}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mret_mstatus: got %h expected %h", got, exp_v); else passed++;
        got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mret_redirect: got %h expected %h", got, exp_v); else passed++;
        // instr_valid stays high through RET; the trap is only taken once back in IDLE.
        @(negedge clk);
        exp_q.push_back({30'd0, 1'b0, 1'b0, 32'h40});
        #2 got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mret_idle_gap: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk);
        instr_valid = 1'b0; csr_reg_rd = 1'b0; ext_irq = 1'b0;
        exp_q.push_back({30'd0, 1'b1, 1'b1, 32'h100});
        #2 got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mret_retrap: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk);
        exp_q.push_back({32'd0, 32'h80});
        csr_read(12'h341, rd_v);
        got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL mret_retrap_mepc: got %h expected %h", got, exp_v); else passed++;
    endtask

    task automatic test_trap_vectored(input logic ext, input logic [31:0] mie_w,
                                      input logic [31:0] exp_tgt, input logic [31:0] exp_cause);
        do_reset();
        csr_write(12'h304, mie_w);
        csr_write(12'h305, 32'h101);
        csr_write(12'h300, 32'h8);
        timer_irq = 1'b1; ext_irq = ext;
        repeat (3) @(negedge clk);
        pc_in = 32'h200; instr_valid = 1'b1;
        exp_q.push_back({30'd0, 1'b1, 1'b1, exp_tgt});
        @(negedge clk);
        instr_valid = 1'b0;
        #2 got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL vec_redirect_%h: got %h expected %h", mie_w, got, exp_v); else passed++;
        @(negedge clk);
        exp_q.push_back({32'd0, exp_cause});
        csr_read(12'h342, rd_v);
        got = {32'd0, rd_v}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL vec_mcause_%h: got %h expected %h", mie_w, got, exp_v); else passed++;
        timer_irq = 1'b0; ext_irq = 1'b0;
    endtask

    task automatic test_reset_mid_trap();
        do_reset();
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        ext_irq = 1'b1;
        repeat (3) @(negedge clk);
        pc_in = 32'h300; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ext_irq = 1'b0;
        exp_q.push_back(64'd0);
        #2 got = {30'd0, trap_busy, epc_taken, epc_out}; exp_v = exp_q.pop_front(); total++;
        if (got !== exp_v) $display("FAIL reset_mid_trap: got %h expected %h", got, exp_v); else passed++;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_csr_rw();
        test_mcycle();
        test_trap_direct();
        test_mret();
        test_trap_vectored(1'b0, 32'h080, 32'h0000_011C, 32'h8000_0007);
        test_trap_vectored(1'b1, 32'h880, 32'h0000_012C, 32'h8000_000B);
        test_reset_mid_trap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
